// File: rtl/audio_rdclk_gen.sv
// rtl/audio_rdclk_gen.sv - paced FIFO reader emitting alternating L/R samples with frame clock
module audio_rdclk_gen #(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl_en,
  input  logic [DIV_W-1:0]  div_val,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_valid,
  output logic              smp_chan,
  output logic              lrclk,
  output logic [CNT_W-1:0]  underrun_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  state_t              state;
  logic                en_q;
  logic [DIV_W-1:0]    cnt;
  logic                nxt_ch;
  logic                rd_q;
  logic                valid_q;
  logic                chan_q;
  logic [DATA_W-1:0]   hold;
  logic [CNT_W-1:0]    urun;
  logic [DIV_W-1:0]    d_eff;
  logic                tick;
  logic                nxt_upd;

  assign d_eff   = (div_val == '0) ? DIV_ONE : div_val;
  assign tick    = (state != IDLE) && (cnt == '0);
  assign nxt_upd = tick ? ~nxt_ch : nxt_ch;

  assign fifo_rd = tick && !fifo_empty;

  // FIFO data arrives one cycle after the pop, so the valid cycle passes it
  // straight through; hold keeps the last sample visible between pulses.
  assign smp_data     = valid_q ? (rd_q ? fifo_data : '0) : hold;
  assign smp_valid    = valid_q;
  assign smp_chan     = chan_q;
  assign lrclk        = chan_q;
  assign underrun_cnt = urun;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      en_q    <= 1'b0;
      cnt     <= '0;
      nxt_ch  <= 1'b0;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      chan_q  <= 1'b0;
      hold    <= '0;
      urun    <= '0;
    end else begin
      en_q    <= ctrl_en;
      rd_q    <= fifo_rd;
      valid_q <= tick;
      if (valid_q) begin
        hold <= smp_data;
      end
      // Empty ticks still advance the channel so L/R alignment survives underruns.
      if (tick) begin
        chan_q <= nxt_ch;
        nxt_ch <= ~nxt_ch;
        if (fifo_empty && (urun != '1)) begin
          urun <= urun + CNT_W'(1);
        end
      end
      case (state)
        IDLE: begin
          if (en_q) begin
            state <= RUN;
            cnt   <= d_eff;
          end else begin
            cnt <= '0;
          end
        end
        RUN: begin
          cnt <= tick ? d_eff : cnt - DIV_ONE;
          if (!en_q) begin
            if (!nxt_upd) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          cnt <= tick ? d_eff : cnt - DIV_ONE;
          if (tick && nxt_ch) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_rdclk_gen.sv
// tb/tb_audio_rdclk_gen.sv - directed bench for audio_rdclk_gen
module tb_audio_rdclk_gen;

  logic        clk;
  logic        reset;
  logic        ctrl_en;
  logic [15:0] div_val;
  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [15:0] smp_data;
  logic        smp_valid;
  logic        smp_chan;
  logic        lrclk;
  logic [15:0] underrun_cnt;
  logic        busy;

  logic        ctrl_en_sat;
  logic [15:0] div_zero;
  logic [15:0] data_zero;
  logic        empty_one;
  logic        sat_rd;
  logic [15:0] sat_data;
  logic        sat_valid;
  logic        sat_chan;
  logic        sat_lr;
  logic [3:0]  sat_cnt;
  logic        sat_busy;

  logic        force_empty;
  logic [15:0] mem [0:63];
  int          nwr;
  int          rp;
  int          errors;
  int          checks;

  audio_rdclk_gen #(.DATA_W(16), .DIV_W(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ctrl_en(ctrl_en), .div_val(div_val),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_chan(smp_chan),
    .lrclk(lrclk), .underrun_cnt(underrun_cnt), .busy(busy)
  );

  audio_rdclk_gen #(.DATA_W(16), .DIV_W(16), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .ctrl_en(ctrl_en_sat), .div_val(div_zero),
    .fifo_data(data_zero), .fifo_empty(empty_one), .fifo_rd(sat_rd),
    .smp_data(sat_data), .smp_valid(sat_valid), .smp_chan(sat_chan),
    .lrclk(sat_lr), .underrun_cnt(sat_cnt), .busy(sat_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-latency-1 FIFO: the popped word appears on fifo_data after the edge.
  initial rp = 0;
  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data <= mem[rp];
      rp <= rp + 1;
    end
  end
  assign fifo_empty = force_empty || (rp == nwr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    mem[nwr] = w;
    nwr = nwr + 1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    nwr = 0;
    fifo_data = 16'h0;
    force_empty = 1'b0;
    reset = 1'b1;
    ctrl_en = 1'b0;
    ctrl_en_sat = 1'b0;
    div_val = 16'd3;
    div_zero = 16'd0;
    data_zero = 16'd0;
    empty_one = 1'b1;
    step();

    chk("rst_rd", fifo_rd, 0);
    chk("rst_valid", smp_valid, 0);
    chk("rst_data", smp_data, 0);
    chk("rst_chan", smp_chan, 0);
    chk("rst_lrclk", lrclk, 0);
    chk("rst_urun", underrun_cnt, 0);
    chk("rst_busy", busy, 0);

    // div_val=3, four words, then stop right after the R sample
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    reset = 1'b0;
    ctrl_en = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      step();
      chk("b_rd", fifo_rd, (c >= 5 && ((c - 5) % 4) == 0) ? 1 : 0);
      chk("b_valid", smp_valid, (c >= 6 && ((c - 6) % 4) == 0) ? 1 : 0);
      chk("b_busy", busy, (c >= 2) ? 1 : 0);
      if (c >= 6 && ((c - 6) % 4) == 0) begin
        chk("b_data", smp_data, 32'h1111 * ((c - 6) / 4 + 1));
        chk("b_chan", smp_chan, ((c - 6) / 4) % 2);
        chk("b_lrclk", lrclk, ((c - 6) / 4) % 2);
      end
    end
    ctrl_en = 1'b0;
    for (int c = 19; c <= 24; c++) begin
      step();
      chk("bs_rd", fifo_rd, 0);
      chk("bs_valid", smp_valid, 0);
      chk("bs_busy", busy, (c == 19) ? 1 : 0);
    end
    chk("bs_hold_data", smp_data, 32'h4444);
    chk("bs_hold_chan", smp_chan, 1);
    chk("bs_urun", underrun_cnt, 0);

    // five samples, reset mid-run, restart on L, then stop after L through DRAIN
    for (int i = 1; i <= 6; i++) push(16'h5000 + 16'(i));
    push(16'h6007);
    ctrl_en = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      step();
      chk("c_rd", fifo_rd, (c >= 5 && ((c - 5) % 4) == 0) ? 1 : 0);
      if (c >= 6 && ((c - 6) % 4) == 0) begin
        chk("c_data", smp_data, 32'h5001 + (c - 6) / 4);
        chk("c_chan", smp_chan, ((c - 6) / 4) % 2);
      end
    end
    reset = 1'b1;
    #1;
    chk("cr_rd", fifo_rd, 0);
    chk("cr_valid", smp_valid, 0);
    chk("cr_data", smp_data, 0);
    chk("cr_chan", smp_chan, 0);
    chk("cr_lrclk", lrclk, 0);
    chk("cr_busy", busy, 0);
    step();
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("c2_rd", fifo_rd, (c == 5) ? 1 : 0);
      chk("c2_valid", smp_valid, (c == 6) ? 1 : 0);
    end
    chk("c2_data", smp_data, 32'h5006);
    chk("c2_chan_L", smp_chan, 0);
    ctrl_en = 1'b0;
    for (int c = 7; c <= 14; c++) begin
      step();
      chk("d_rd", fifo_rd, (c == 9) ? 1 : 0);
      chk("d_valid", smp_valid, (c == 10) ? 1 : 0);
      if (c <= 9) chk("d_busy_drain", busy, 1);
      if (c >= 11) chk("d_busy_idle", busy, 0);
      if (c == 10) begin
        chk("d_data", smp_data, 32'h6007);
        chk("d_chan_R", smp_chan, 1);
      end
    end

    // div_val=0 behaves as 1: pop every 2 cycles from cycle 3
    pulse_reset();
    div_val = 16'd0;
    ctrl_en = 1'b1;
    for (int i = 1; i <= 4; i++) push(16'h7000 + 16'(i));
    for (int c = 1; c <= 10; c++) begin
      step();
      chk("z_rd", fifo_rd, (c >= 3 && (c % 2) == 1) ? 1 : 0);
      chk("z_valid", smp_valid, (c >= 4 && (c % 2) == 0) ? 1 : 0);
      if (c >= 4 && (c % 2) == 0) begin
        chk("z_data", smp_data, 32'h7001 + (c - 4) / 2);
        chk("z_chan", smp_chan, ((c - 4) / 2) % 2);
      end
    end
    chk("z_urun", underrun_cnt, 0);

    // div_val=2, FIFO empty at the 2nd and 3rd ticks
    ctrl_en = 1'b0;
    pulse_reset();
    div_val = 16'd2;
    ctrl_en = 1'b1;
    push(16'h8001); push(16'h8002);
    for (int c = 1; c <= 14; c++) begin
      step();
      chk("u_rd", fifo_rd, (c == 4 || c == 13) ? 1 : 0);
      chk("u_valid", smp_valid, (c == 5 || c == 8 || c == 11 || c == 14) ? 1 : 0);
      case (c)
        5:  begin chk("u_d1", smp_data, 32'h8001); chk("u_c1", smp_chan, 0); end
        8:  begin chk("u_d2", smp_data, 0); chk("u_c2", smp_chan, 1); chk("u_cnt1", underrun_cnt, 1); end
        11: begin chk("u_d3", smp_data, 0); chk("u_c3", smp_chan, 0); end
        14: begin chk("u_d4", smp_data, 32'h8002); chk("u_c4", smp_chan, 1); end
        default: ;
      endcase
      if (c == 5) force_empty = 1'b1;
      if (c == 11) force_empty = 1'b0;
    end
    chk("u_cnt2", underrun_cnt, 2);
    ctrl_en = 1'b0;

    // CNT_W=4 instance with a permanently empty FIFO saturates at 15
    ctrl_en_sat = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      step();
      chk("s_rd", sat_rd, 0);
      if (c == 4) chk("s_cnt1", sat_cnt, 1);
      if (c == 22) chk("s_cnt10", sat_cnt, 10);
      if (c == 32) chk("s_cnt15", sat_cnt, 15);
    end
    chk("s_sat", sat_cnt, 15);
    chk("s_data", sat_data, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
